// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with a byte register file.
// Decodes START/STOP/address/data from the synchronized SCL/SDA pins, ACKs
// matched transfers, writes bytes through an auto-incrementing pointer and
// returns register bytes on reads. SDA is driven open-drain via sda_oe only.
`timescale 1ns/1ps
module i2c_target_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NUM_REGS   = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        scl_in,
  input  logic                        sda_in,
  output logic                        sda_oe,
  output logic                        busy,
  output logic                        wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr,
  output logic [7:0]                  wr_data,
  input  logic [$clog2(NUM_REGS)-1:0] host_addr,
  output logic [7:0]                  host_rdata
);
  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_t;

  state_t                     r_state, w_state_nxt;
  logic [2:0]                 r_scl_sync, r_sda_sync;
  logic [3:0]                 r_bitcnt, w_bitcnt_nxt;
  logic [7:0]                 r_shift, w_shift_nxt;
  logic [AW-1:0]              r_ptr, w_ptr_nxt, w_ptr_inc;
  logic                       r_sda_oe, w_sda_oe_nxt;
  logic                       r_busy, w_busy_nxt;
  logic                       r_rw, w_rw_nxt;
  logic                       r_mnack, w_mnack_nxt;
  logic                       r_wr_strobe, w_we;
  logic [AW-1:0]              r_wr_addr, w_wr_addr_nxt;
  logic [7:0]                 r_wr_data, w_wr_data_nxt;
  logic [NUM_REGS-1:0][7:0]   r_regs;

  logic       w_sda, w_scl_rise, w_scl_fall, w_scl_hi, w_start, w_stop;
  logic [7:0] w_byte, w_rd_byte, w_rd_byte_inc;

  // Pin synchronizers: [1] is the synchronized level, [2] the edge-detect history.
  // Reset to 1 so an idle (pulled-up) bus produces no edges after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_scl_sync <= 3'b111;
      r_sda_sync <= 3'b111;
    end else begin
      r_scl_sync <= {r_scl_sync[1:0], scl_in};
      r_sda_sync <= {r_sda_sync[1:0], sda_in};
    end
  end

  assign w_sda      = r_sda_sync[1];
  assign w_scl_rise =  r_scl_sync[1] & ~r_scl_sync[2];
  assign w_scl_fall = ~r_scl_sync[1] &  r_scl_sync[2];
  // SCL high on both taps: an SDA edge coinciding with an SCL edge is data, not START/STOP.
  assign w_scl_hi   =  r_scl_sync[1] &  r_scl_sync[2];
  assign w_start    = ~r_sda_sync[1] &  r_sda_sync[2] & w_scl_hi;
  assign w_stop     =  r_sda_sync[1] & ~r_sda_sync[2] & w_scl_hi;

  assign w_byte        = {r_shift[6:0], w_sda};
  assign w_ptr_inc     = r_ptr + AW'(1);
  assign w_rd_byte     = r_regs[r_ptr];
  assign w_rd_byte_inc = r_regs[w_ptr_inc];

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and datapath decisions. Bits are taken on SCL rise; sda_oe only
  // moves on SCL fall. In ACK states bitcnt=8 before the 9th rise, 9 after it.
  always_comb begin
    w_state_nxt   = r_state;
    w_bitcnt_nxt  = r_bitcnt;
    w_shift_nxt   = r_shift;
    w_ptr_nxt     = r_ptr;
    w_sda_oe_nxt  = r_sda_oe;
    w_busy_nxt    = r_busy;
    w_rw_nxt      = r_rw;
    w_mnack_nxt   = r_mnack;
    w_we          = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    if (w_stop) begin
      w_state_nxt  = S_IDLE;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
      w_bitcnt_nxt = 4'd0;
    end else if (w_start) begin
      w_state_nxt  = S_ADDR;
      w_sda_oe_nxt = 1'b0;
      w_bitcnt_nxt = 4'd0;
    end else begin
      case (r_state)
        S_ADDR, S_PTR, S_WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt  = w_byte;
            w_bitcnt_nxt = r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd7) begin
              if (r_state == S_ADDR) begin
                if (w_byte[7:1] == SLAVE_ADDR) begin
                  w_state_nxt = S_ADDR_ACK;
                  w_busy_nxt  = 1'b1;
                  w_rw_nxt    = w_byte[0];
                end else begin
                  w_state_nxt = S_IGNORE;
                  w_busy_nxt  = 1'b0;
                end
              end else if (r_state == S_PTR) begin
                w_ptr_nxt   = w_byte[AW-1:0];
                w_state_nxt = S_PTR_ACK;
              end else begin
                w_we          = 1'b1;
                w_wr_addr_nxt = r_ptr;
                w_wr_data_nxt = w_byte;
                w_ptr_nxt     = w_ptr_inc;
                w_state_nxt   = S_WDATA_ACK;
              end
            end
          end
        end
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK, S_RDATA_ACK: begin
          if (w_scl_rise) begin
            w_bitcnt_nxt = 4'd9;
            w_mnack_nxt  = w_sda;
          end else if (w_scl_fall && r_bitcnt == 4'd8) begin
            // We ACK our own slots; the master's ACK slot after a read byte is released.
            w_sda_oe_nxt = (r_state != S_RDATA_ACK);
          end else if (w_scl_fall && r_bitcnt == 4'd9) begin
            w_bitcnt_nxt = 4'd0;
            w_sda_oe_nxt = 1'b0;
            if (r_state == S_ADDR_ACK && r_rw) begin
              w_state_nxt  = S_RDATA;
              w_shift_nxt  = w_rd_byte;
              w_sda_oe_nxt = ~w_rd_byte[7];
            end else if (r_state == S_ADDR_ACK) begin
              w_state_nxt = S_PTR;
            end else if (r_state == S_RDATA_ACK) begin
              if (r_mnack) begin
                w_state_nxt = S_IGNORE;
              end else begin
                w_state_nxt  = S_RDATA;
                w_ptr_nxt    = w_ptr_inc;
                w_shift_nxt  = w_rd_byte_inc;
                w_sda_oe_nxt = ~w_rd_byte_inc[7];
              end
            end else begin
              w_state_nxt = S_WDATA;
            end
          end
        end
        S_RDATA: begin
          if (w_scl_rise) begin
            w_bitcnt_nxt = r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd7) w_state_nxt = S_RDATA_ACK;
          end else if (w_scl_fall && r_bitcnt != 4'd0) begin
            w_shift_nxt  = {r_shift[6:0], 1'b0};
            w_sda_oe_nxt = ~r_shift[6];
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers; the reset clears sda_oe asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bitcnt    <= 4'd0;
      r_shift     <= 8'h00;
      r_ptr       <= '0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_rw        <= 1'b0;
      r_mnack     <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 8'h00;
    end else begin
      r_bitcnt    <= w_bitcnt_nxt;
      r_shift     <= w_shift_nxt;
      r_ptr       <= w_ptr_nxt;
      r_sda_oe    <= w_sda_oe_nxt;
      r_busy      <= w_busy_nxt;
      r_rw        <= w_rw_nxt;
      r_mnack     <= w_mnack_nxt;
      r_wr_strobe <= w_we;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
    end
  end

  // Register file, written on the same edge that raises wr_strobe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
    end else if (w_we) begin
      r_regs[r_ptr] <= w_byte;
    end
  end

  assign sda_oe     = r_sda_oe;
  assign busy       = r_busy;
  assign wr_strobe  = r_wr_strobe;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign host_rdata = r_regs[host_addr];
endmodule
